// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ requesters, the arbiter and one FIFO write port.
// The arbiter uses the master modport; requesters and the FIFO model use slave.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_last_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       grant_o;
  logic                     fifo_full_i;
  logic                     fifo_wr_en_o;
  logic [WIDTH-1:0]         fifo_wr_data_o;
  logic                     busy_o;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
    output req_ready_o, grant_o, fifo_wr_en_o, fifo_wr_data_o, busy_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, fifo_full_i,
    input  req_ready_o, grant_o, fifo_wr_en_o, fifo_wr_data_o, busy_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter that owns a FIFO write port.
// It never writes while the FIFO is full, and it inserts one idle cycle after every release.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  fifo_wr_arbiter_if.master    bus
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W1 = IDX_W + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_reg;
  logic [NUM_REQ-1:0]   grant_reg;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [CNT_WIDTH-1:0] beat_cnt_reg;
  logic                 busy_reg;

  logic [IDX_W-1:0]     gidx;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     rr_next;
  logic [IDX_W1-1:0]    cand;
  logic                 sel_found;
  logic                 g_valid;
  logic                 g_last;
  logic                 beat;
  logic                 release_now;
  logic [WIDTH-1:0]     data_sel;
  logic [NUM_REQ-1:0][WIDTH-1:0] masked_data;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign masked_data[gi] = grant_reg[gi] ? bus.req_data_i[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  // The grant is one-hot, so OR-ing the masked lanes selects the granted lane.
  always_comb begin
    data_sel = '0;
    gidx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_sel = data_sel | masked_data[i];
      if (grant_reg[i]) gidx = IDX_W'(i);
    end
  end

  // Walk the candidates from the highest offset down, so the lowest offset from rr_ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + IDX_W1'(k);
      if (cand >= IDX_W1'(NUM_REQ)) cand = cand - IDX_W1'(NUM_REQ);
      if (bus.req_valid_i[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign g_valid     = |(bus.req_valid_i & grant_reg);
  assign g_last      = |(bus.req_last_i & grant_reg);
  // rst_ni gating keeps the reset cycle free of writes even though the grant is still registered.
  assign beat        = (state_reg == GRANT) & g_valid & ~bus.fifo_full_i & rst_ni;
  assign release_now = (beat & (g_last | (beat_cnt_reg == CNT_WIDTH'(BURST_MAX - 1)))) | ~g_valid;
  assign rr_next     = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

  assign bus.req_ready_o    = grant_reg & {NUM_REQ{~bus.fifo_full_i & rst_ni}};
  assign bus.grant_o        = grant_reg;
  assign bus.fifo_wr_en_o   = beat;
  assign bus.fifo_wr_data_o = beat ? data_sel : '0;
  assign bus.busy_o         = busy_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            grant_reg    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
            beat_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grant_reg  <= '0;
            rr_ptr_reg <= rr_next;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end else if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
        end
        default: begin
          grant_reg <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant_reg));
  a_no_write_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(beat && bus.fifo_full_i));
  a_write_busy:    assert property (@(posedge clk_i) disable iff (!rst_ni) !beat || busy_reg);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus hand-written corner sequences.
module tb_fifo_wr_arbiter;
  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;
  int   wr_count;
  int   wr_base;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST_MAX(4), .CNT_WIDTH(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  e_grant;
    logic [3:0]  e_ready;
    logic        e_we;
    logic [7:0]  e_wd;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_n, input logic [3:0] valid, input logic [31:0] data,
                              input logic [3:0] last, input logic full, input logic [3:0] eg,
                              input logic [3:0] er, input logic ewe, input logic [7:0] ewd,
                              input logic eb);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.data = data; v.last = last; v.full = full;
    v.e_grant = eg; v.e_ready = er; v.e_we = ewe; v.e_wd = ewd; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
  task automatic run(input vec_t v, input string nm);
    @(negedge clk_i);
    rst_ni          = v.rst_n;
    bus.req_valid_i = v.valid;
    bus.req_data_i  = v.data;
    bus.req_last_i  = v.last;
    bus.fifo_full_i = v.full;
    #1;
    $display("%-10s grant=%b ready=%b we=%b wd=%h busy=%b", nm, bus.grant_o, bus.req_ready_o,
             bus.fifo_wr_en_o, bus.fifo_wr_data_o, bus.busy_o);
    if (bus.fifo_wr_en_o === 1'b1) wr_count++;
    chk({nm, ".grant"}, 32'(bus.grant_o), 32'(v.e_grant));
    chk({nm, ".ready"}, 32'(bus.req_ready_o), 32'(v.e_ready));
    chk({nm, ".wr_en"}, 32'(bus.fifo_wr_en_o), 32'(v.e_we));
    chk({nm, ".wr_data"}, 32'(bus.fifo_wr_data_o), 32'(v.e_wd));
    chk({nm, ".busy"}, 32'(bus.busy_o), 32'(v.e_busy));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    wr_count = 0;
    rst_ni          = 1'b0;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    bus.fifo_full_i = 1'b0;
    @(posedge clk_i);

    // Reset with every requester valid, then the first grant goes to req 0.
    tbl.push_back(mk(0, 4'hF, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'hF, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'hF, 32'hA0, 4'h1, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'hF, 32'hA0, 4'h1, 0, 4'h1, 4'h1, 1, 8'hA0, 1));
    tbl.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    // Single requester burst on req 2, last on the fourth beat.
    tbl.push_back(mk(1, 4'h4, 32'h0010_0000, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'h4, 32'h0010_0000, 4'h0, 0, 4'h4, 4'h4, 1, 8'h10, 1));
    tbl.push_back(mk(1, 4'h4, 32'h0011_0000, 4'h0, 0, 4'h4, 4'h4, 1, 8'h11, 1));
    tbl.push_back(mk(1, 4'h4, 32'h0012_0000, 4'h0, 0, 4'h4, 4'h4, 1, 8'h12, 1));
    tbl.push_back(mk(1, 4'h4, 32'h0013_0000, 4'h4, 0, 4'h4, 4'h4, 1, 8'h13, 1));
    tbl.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    // rr_ptr is now 3: req 3 beats req 0.
    tbl.push_back(mk(1, 4'h9, 32'h3300_0000, 4'h8, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'h9, 32'h3300_0000, 4'h8, 0, 4'h8, 4'h8, 1, 8'h33, 1));
    tbl.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    // Burst cap: req 0 never asserts last, so it is cut after 4 beats and then re-granted.
    tbl.push_back(mk(1, 4'h1, 32'h50, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'h1, 32'h50, 4'h0, 0, 4'h1, 4'h1, 1, 8'h50, 1));
    tbl.push_back(mk(1, 4'h1, 32'h51, 4'h0, 0, 4'h1, 4'h1, 1, 8'h51, 1));
    tbl.push_back(mk(1, 4'h1, 32'h52, 4'h0, 0, 4'h1, 4'h1, 1, 8'h52, 1));
    tbl.push_back(mk(1, 4'h1, 32'h53, 4'h0, 0, 4'h1, 4'h1, 1, 8'h53, 1));
    tbl.push_back(mk(1, 4'h1, 32'h54, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'h1, 32'h54, 4'h0, 0, 4'h1, 4'h1, 1, 8'h54, 1));
    tbl.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 4'h1, 4'h1, 0, 8'h00, 1));
    tbl.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0));

    foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i));

    // Round robin: every requester valid with single-beat bursts.
    run(mk(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0), "rr_reset");
    for (int i = 0; i < 5; i++) begin
      run(mk(1, 4'hF, 32'hC3C2C1C0, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00, 0), "rr_idle");
      run(mk(1, 4'hF, 32'hC3C2C1C0, 4'hF, 0, 4'(1 << (i % 4)), 4'(1 << (i % 4)), 1,
             8'(8'hC0 + (i % 4)), 1), "rr_grant");
    end

    // Full stall after the first beat: the grant holds and beats resume right after.
    run(mk(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0), "fs_reset");
    wr_base = wr_count;
    run(mk(1, 4'h1, 32'h60, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0), "fs_idle");
    run(mk(1, 4'h1, 32'h60, 4'h0, 0, 4'h1, 4'h1, 1, 8'h60, 1), "fs_beat");
    for (int i = 0; i < 3; i++)
      run(mk(1, 4'h1, 32'h61, 4'h0, 1, 4'h1, 4'h0, 0, 8'h00, 1), "fs_full");
    for (int j = 1; j < 4; j++)
      run(mk(1, 4'h1, 32'(8'h60 + j), 4'h0, 0, 4'h1, 4'h1, 1, 8'(8'h60 + j), 1), "fs_beat");
    run(mk(1, 4'h0, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0), "fs_bubble");
    chk("fs_writes", 32'(wr_count - wr_base), 32'd4);

    // Withdraw: req 1 drops valid after two beats, so the next pick starts at req 2.
    run(mk(1, 4'h2, 32'h7000, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0), "wd_idle");
    run(mk(1, 4'h2, 32'h7000, 4'h0, 0, 4'h2, 4'h2, 1, 8'h70, 1), "wd_beat");
    run(mk(1, 4'h2, 32'h7100, 4'h0, 0, 4'h2, 4'h2, 1, 8'h71, 1), "wd_beat");
    run(mk(1, 4'h0, 32'h0, 4'h0, 0, 4'h2, 4'h2, 0, 8'h00, 1), "wd_drop");
    run(mk(1, 4'hF, 32'h0092_0000, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00, 0), "wd_idle2");
    run(mk(1, 4'hF, 32'h0092_0000, 4'hF, 0, 4'h4, 4'h4, 1, 8'h92, 1), "wd_rr2");

    // Reset during beat 2: no write that cycle, and arbitration restarts at req 0.
    run(mk(1, 4'h2, 32'h8000, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0), "rm_idle");
    run(mk(1, 4'h2, 32'h8000, 4'h0, 0, 4'h2, 4'h2, 1, 8'h80, 1), "rm_beat");
    run(mk(0, 4'h2, 32'h8100, 4'h0, 0, 4'h2, 4'h0, 0, 8'h00, 1), "rm_rst");
    run(mk(1, 4'hF, 32'h0000_00A0, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00, 0), "rm_idle2");
    run(mk(1, 4'hF, 32'h0000_00A0, 4'hF, 0, 4'h1, 4'h1, 1, 8'hA0, 1), "rm_rr0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
